// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and opcode constants for the RV32I multi-cycle control FSM.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  // instr[6:2] opcode field values
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_JALR = 2'd2} pc_sel_e;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_e;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_FUNCT = 2'd1, ALU_PASS_B = 2'd2} alu_op_e;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_LUI,
    CLS_AUIPC, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILLEGAL
  } op_cls_e;

  typedef struct packed {
    op_cls_e cls;
    logic    legal;
    logic    op_a_sel;
    logic    op_b_sel;
    alu_op_e alu_op;
    wb_sel_e wb_sel;
  } dec_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode decode: instruction class, legality and datapath selects.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] instr,
  output dec_t       dec
);

  always_comb begin
    dec          = '0;
    dec.cls      = CLS_ILLEGAL;
    dec.alu_op   = ALU_ADD;
    dec.wb_sel   = WB_ALU;
    case (instr[6:2])
      OPC_LOAD:   begin dec.cls = CLS_LOAD;  dec.op_b_sel = 1'b1; dec.wb_sel = WB_MEM; end
      OPC_STORE:  begin dec.cls = CLS_STORE; dec.op_b_sel = 1'b1; end
      OPC_OP_IMM: begin dec.cls = CLS_OP_IMM; dec.op_b_sel = 1'b1; dec.alu_op = ALU_FUNCT; end
      OPC_OP:     begin dec.cls = CLS_OP;    dec.alu_op = ALU_FUNCT; end
      OPC_LUI:    begin dec.cls = CLS_LUI;   dec.op_b_sel = 1'b1; dec.alu_op = ALU_PASS_B; end
      OPC_AUIPC:  begin dec.cls = CLS_AUIPC; dec.op_a_sel = 1'b1; dec.op_b_sel = 1'b1; end
      OPC_BRANCH: dec.cls = CLS_BRANCH;
      OPC_JAL:    begin dec.cls = CLS_JAL;   dec.wb_sel = WB_PC4; end
      OPC_JALR:   begin dec.cls = CLS_JALR;  dec.wb_sel = WB_PC4; end
      default:    dec.cls = CLS_ILLEGAL;
    endcase
    dec.legal = (instr[1:0] == 2'b11) && (dec.cls != CLS_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing with sticky trap.
// Optional cycle/instret counters enabled by MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TMO_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        br_taken_i,
  input  logic        imem_ack_i,
  input  logic        dmem_ack_i,
  output logic        imem_req_o,
  output logic        ir_we_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        rd_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        op_a_sel_o,
  output logic        op_b_sel_o,
  output logic [1:0]  alu_op_o,
  output logic [2:0]  state_o,
  output logic        trap_o
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_o
`endif
);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  dec_t             dec;
  logic             unused_instr;

  assign unused_instr = ^instr_i[31:7];

  ctrl_decode u_decode (
    .instr (instr_i[6:0]),
    .dec   (dec)
  );

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state and Moore outputs; ack only qualifies strobes in the wait states
  always_comb begin
    state_d    = state_q;
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = PC_PLUS4;
    rd_we_o    = 1'b0;
    wb_sel_o   = WB_ALU;
    op_a_sel_o = 1'b0;
    op_b_sel_o = 1'b0;
    alu_op_o   = ALU_ADD;
    trap_o     = 1'b0;
    if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
      op_a_sel_o = dec.op_a_sel;
      op_b_sel_o = dec.op_b_sel;
      alu_op_o   = dec.alu_op;
    end
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_we_o = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo_hit) begin
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: state_d = dec.legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (dec.cls == CLS_BRANCH) begin
          pc_we_o  = 1'b1;
          pc_sel_o = br_taken_i ? PC_IMM : PC_PLUS4;
          state_d  = ST_FETCH;
        end else if (dec.cls inside {CLS_LOAD, CLS_STORE}) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (dec.cls == CLS_STORE);
        if (dmem_ack_i) begin
          if (dec.cls == CLS_STORE) begin
            pc_we_o = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmo_hit) begin
          state_d = ST_TRAP;
        end
      end
      ST_WB: begin
        rd_we_o  = 1'b1;
        pc_we_o  = 1'b1;
        wb_sel_o = dec.wb_sel;
        if (dec.cls == CLS_JAL)       pc_sel_o = PC_IMM;
        else if (dec.cls == CLS_JALR) pc_sel_o = PC_JALR;
        state_d = ST_FETCH;
      end
      ST_TRAP: trap_o = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  // Wait counter runs only while parked in FETCH/MEM
  always_comb begin
    tmo_d = '0;
    if ((state_d == state_q) && (state_q inside {ST_FETCH, ST_MEM})) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_o <= '0;
      instret_o   <= '0;
    end else begin
      if (!(state_q inside {ST_IDLE, ST_TRAP})) cycle_cnt_o <= cycle_cnt_o + 32'd1;
      if (pc_we_o) instret_o <= instret_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed plus randomized instruction streams.
module tb_multicycle_ctrl;

  localparam int unsigned TMO = 8;

  localparam int K_LOAD = 0, K_STORE = 1, K_OPIMM = 2, K_OP = 3, K_LUI = 4;
  localparam int K_AUIPC = 5, K_BRANCH = 6, K_JAL = 7, K_JALR = 8, K_ILL = 9;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [31:0] instr_i = '0;
  logic        br_taken_i = 1'b0;
  logic        imem_ack_i = 1'b0;
  logic        dmem_ack_i = 1'b0;
  logic        imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, pc_we_o, rd_we_o;
  logic        op_a_sel_o, op_b_sel_o, trap_o;
  logic [1:0]  pc_sel_o, wb_sel_o, alu_op_o;
  logic [2:0]  state_o;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_o, instret_o;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .br_taken_i(br_taken_i),
    .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i), .imem_req_o(imem_req_o),
    .ir_we_o(ir_we_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .rd_we_o(rd_we_o), .wb_sel_o(wb_sel_o),
    .op_a_sel_o(op_a_sel_o), .op_b_sel_o(op_b_sel_o), .alu_op_o(alu_op_o),
    .state_o(state_o), .trap_o(trap_o)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
`endif
  );

  // Expected output vector in a fixed field order
  function automatic logic [17:0] ev(int st, bit imem, bit irwe, bit dreq, bit dwe, bit pcwe,
                                     int pcsel, bit rdwe, int wbsel, logic [3:0] sel, bit trap);
    return {imem, irwe, dreq, dwe, pcwe, 2'(pcsel), rdwe, 2'(wbsel), sel, 3'(st), trap};
  endfunction

  function automatic int kind(logic [31:0] ins);
    case (ins[6:0])
      7'h03: return K_LOAD;
      7'h23: return K_STORE;
      7'h13: return K_OPIMM;
      7'h33: return K_OP;
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      7'h63: return K_BRANCH;
      7'h6F: return K_JAL;
      7'h67: return K_JALR;
      default: return K_ILL;
    endcase
  endfunction

  // {op_a_sel, op_b_sel, alu_op}
  function automatic logic [3:0] sel_of(int k);
    case (k)
      K_OP:              return 4'b0001;
      K_OPIMM:           return 4'b0101;
      K_LOAD, K_STORE:   return 4'b0100;
      K_LUI:             return 4'b0110;
      K_AUIPC:           return 4'b1100;
      default:           return 4'b0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [17:0] exp);
    logic [17:0] act;
    act = {imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, pc_we_o, pc_sel_o, rd_we_o,
           wb_sel_o, op_a_sel_o, op_b_sel_o, alu_op_o, state_o, trap_o};
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %05h expected %05h", tag, act, exp);
    end
  endtask

  task automatic tick(input string tag, input logic [17:0] exp);
    @(negedge clk_i);
    check(tag, exp);
    @(posedge clk_i);
    #1;
  endtask

  task automatic noise();
    imem_ack_i = 1'($urandom_range(0, 1));
    dmem_ack_i = 1'($urandom_range(0, 1));
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      tick("trap", ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 1));
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    #1;
    check("reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 0));
`ifdef MULTICYCLE_CTRL_PERF_EN
    vectors++;
    assert (cycle_cnt_o === 32'd0 && instret_o === 32'd0) else begin
      miscompares++;
      $error("FAIL perf_reset: observed %h/%h expected 0/0", cycle_cnt_o, instret_o);
    end
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 0));
    @(posedge clk_i);
    #1;
  endtask

  // Walk one instruction through its phases; a delay >= TMO means the ack never comes
  task automatic run_instr(input logic [31:0] ins, input int idly, input int ddly, input bit br);
    int k;
    logic [3:0] s;
    int nf, nm, wbs, pcs;
    bit last;
    k = kind(ins);
    s = sel_of(k);
    instr_i = ins;
    br_taken_i = br;
    nf = (idly < int'(TMO)) ? idly + 1 : int'(TMO);
    for (int i = 0; i < nf; i++) begin
      last = (i == idly);
      imem_ack_i = last;
      dmem_ack_i = 1'($urandom_range(0, 1));
      tick("fetch", ev(1, 1, last, 0, 0, 0, 0, 0, 0, 4'b0, 0));
    end
    if (idly >= int'(TMO)) begin
      trap_cycles(3);
      return;
    end
    noise();
    tick("decode", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 0));
    if (k == K_ILL) begin
      trap_cycles(20);
      return;
    end
    noise();
    if (k == K_BRANCH) begin
      tick("exec_br", ev(3, 0, 0, 0, 0, 1, br ? 1 : 0, 0, 0, s, 0));
      return;
    end
    tick("exec", ev(3, 0, 0, 0, 0, 0, 0, 0, 0, s, 0));
    if (k == K_LOAD || k == K_STORE) begin
      nm = (ddly < int'(TMO)) ? ddly + 1 : int'(TMO);
      for (int j = 0; j < nm; j++) begin
        last = (j == ddly);
        dmem_ack_i = last;
        imem_ack_i = 1'($urandom_range(0, 1));
        tick("mem", ev(4, 0, 0, 1, k == K_STORE, (k == K_STORE) && last, 0, 0, 0, s, 0));
      end
      if (ddly >= int'(TMO)) begin
        trap_cycles(3);
        return;
      end
      if (k == K_STORE) return;
    end
    wbs = (k == K_LOAD) ? 1 : (k == K_JAL || k == K_JALR) ? 2 : 0;
    pcs = (k == K_JAL) ? 1 : (k == K_JALR) ? 2 : 0;
    noise();
    tick("wb", ev(5, 0, 0, 0, 0, 1, pcs, 1, wbs, s, 0));
  endtask

  logic [6:0]  legal_opc [9] = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67};

  initial begin
    logic [31:0] r;
    #1;
    do_reset();
    run_instr(32'h00500093, 2, 0, 0);   // ADDI
    run_instr(32'h0000A103, 0, 2, 0);   // LW, ack on 3rd MEM cycle
    run_instr(32'h0020A023, 1, 1, 0);   // SW
    run_instr(32'h00208463, 0, 0, 1);   // BEQ taken
    run_instr(32'h00208463, 0, 0, 0);   // BEQ not taken
    run_instr(32'h000100E7, 0, 0, 0);   // JALR
    run_instr(32'h008000EF, 0, 0, 0);   // JAL
    run_instr(32'h123450B7, 0, 0, 0);   // LUI
    run_instr(32'h00001097, 0, 0, 0);   // AUIPC
    run_instr(32'h002081B3, 0, 0, 0);   // ADD
    run_instr(32'h00500093, TMO - 1, 0, 0);   // ack in terminal fetch cycle
    run_instr(32'h0020A023, 0, TMO - 1, 0);   // ack in terminal mem cycle
    for (int n = 0; n < 60; n++) begin
      r = $urandom();
      run_instr({r[31:7], legal_opc[$urandom_range(0, 8)]},
                $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), 1'($urandom_range(0, 1)));
    end
    run_instr(32'hFFFFFFFF, 0, 0, 0);   // illegal opcode
    do_reset();
    run_instr(32'h00500091, 1, 0, 0);   // low bits not 11
    do_reset();
    run_instr(32'h0000000F, 0, 0, 0);   // FENCE unsupported
    do_reset();
    run_instr(32'h00500093, TMO, 0, 0); // fetch timeout
    do_reset();
    run_instr(32'h0000A103, 0, TMO, 0); // mem timeout
    do_reset();
    // Reset in the middle of a load's MEM phase
    instr_i = 32'h0000A103;
    imem_ack_i = 1'b1;
    tick("fetch", ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0, 0));
    imem_ack_i = 1'b0;
    tick("decode", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 0));
    tick("exec", ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 0));
    tick("mem", ev(4, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0100, 0));
    #2;
    do_reset();
    run_instr(32'h00500093, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
